// File: rtl/vr_pipe_serializer.sv
// Width-reducing serializer: accepts one IN_W-bit word and emits it as RATIO
// OUT_W-bit beats, LSB slice first, with zero-bubble back-to-back words.
module vr_pipe_serializer #(
  parameter  int IN_W  = 32,
  parameter  int RATIO = 4,
  localparam int OUT_W = IN_W / RATIO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if ((RATIO < 2) || ((IN_W % RATIO) != 0)) begin : g_param_err
    $error("vr_pipe_serializer: RATIO must be >= 2 and divide IN_W");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [IN_W-1:0]   word_r, word_s;

  logic              send_s;
  logic              last_s;
  logic              beat_xfer_s;
  logic              word_xfer_s;
  logic              in_ready_s;
  logic [OUT_W-1:0]  slice_s [RATIO];

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slice_s[g] = word_r[g*OUT_W +: OUT_W];
  end

  assign send_s      = (state_r == ST_SEND);
  assign last_s      = (cnt_r == LAST_CNT);
  assign beat_xfer_s = send_s && out_ready;
  assign word_xfer_s = in_valid && in_ready_s;

  // Accept a word when empty, or on the cycle the final beat leaves.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_SEND: in_ready_s = beat_xfer_s && last_s;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Next-state: a new word takes priority so the last beat can hand over seamlessly.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    if (word_xfer_s) begin
      word_s  = in_data;
      cnt_s   = {CNT_W{1'b0}};
      state_s = ST_SEND;
    end else if (beat_xfer_s) begin
      if (last_s) begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_IDLE;
      end else begin
        cnt_s   = cnt_r + CNT_W'(1);
        state_s = ST_SEND;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, beat index and held word; reset discards any partially sent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      word_r  <= {IN_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = send_s;
  assign busy      = send_s;
  assign out_last  = send_s && last_s;
  assign out_data  = slice_s[cnt_r];

endmodule

// File: tb/tb_vr_pipe_serializer.sv
// Directed bench for vr_pipe_serializer: 32/4 and 24/3 instances, checked
// with immediate assertions against hand-computed beats.
module tb_vr_pipe_serializer;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [23:0] b_in_data;
  logic [7:0]  b_out_data;

  vr_pipe_serializer #(.IN_W(32), .RATIO(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
  );

  vr_pipe_serializer #(.IN_W(24), .RATIO(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, a_out_data},  {24'd0, d});
    chk({tag, "_last"},  {31'd0, a_out_last},  {31'd0, l});
  endtask

  task automatic idle_a(input string tag);
    chk({tag, "_valid"}, {31'd0, a_out_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, a_busy},      32'd0);
    chk({tag, "_rdy"},   {31'd0, a_in_ready},  32'd1);
  endtask

  // Advance one cycle: land on the next falling edge, then let comb logic settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 32'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 24'd0; b_out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    idle_a("rst_a");
    chk("rst_a_last", {31'd0, a_out_last}, 32'd0);
    chk("rst_a_data", {24'd0, a_out_data}, 32'd0);
    chk("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst_b_rdy",   {31'd0, b_in_ready},  32'd1);

    // Single word, out_ready held high
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; #1;
    chk("w1_accept_rdy", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0; a_in_data = 32'h0; #1;
    beat_a("w1_b0", 8'hAA, 1'b0); tick();
    beat_a("w1_b1", 8'hBB, 1'b0); tick();
    beat_a("w1_b2", 8'hCC, 1'b0); tick();
    beat_a("w1_b3", 8'hDD, 1'b1);
    chk("w1_b3_rdy", {31'd0, a_in_ready}, 32'd1);
    tick();
    idle_a("w1_end");

    // Back-to-back words, no bubble
    a_in_valid = 1'b1; a_in_data = 32'h44332211; #1;
    tick();
    a_in_data = 32'h88776655; #1;
    beat_a("bb_b0", 8'h11, 1'b0);
    chk("bb_b0_rdy", {31'd0, a_in_ready}, 32'd0);
    tick();
    beat_a("bb_b1", 8'h22, 1'b0); tick();
    beat_a("bb_b2", 8'h33, 1'b0); tick();
    beat_a("bb_b3", 8'h44, 1'b1);
    chk("bb_b3_rdy", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0; a_in_data = 32'h0; #1;
    beat_a("bb_b4", 8'h55, 1'b0); tick();
    beat_a("bb_b5", 8'h66, 1'b0); tick();
    beat_a("bb_b6", 8'h77, 1'b0); tick();
    beat_a("bb_b7", 8'h88, 1'b1); tick();
    idle_a("bb_end");

    // Backpressure for 3 cycles on the second beat
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; #1;
    tick();
    a_in_valid = 1'b0; #1;
    beat_a("bp_b0", 8'hAA, 1'b0); tick();
    a_out_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      beat_a("bp_hold", 8'hBB, 1'b0);
      chk("bp_hold_rdy", {31'd0, a_in_ready}, 32'd0);
      tick();
    end
    a_out_ready = 1'b1; #1;
    beat_a("bp_b1", 8'hBB, 1'b0); tick();
    beat_a("bp_b2", 8'hCC, 1'b0); tick();
    beat_a("bp_b3", 8'hDD, 1'b1); tick();
    idle_a("bp_end");

    // Word offered mid-send waits for the final beat
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; #1;
    tick();
    a_in_valid = 1'b0; #1;
    beat_a("ms_b0", 8'hAA, 1'b0); tick();
    a_in_valid = 1'b1; a_in_data = 32'h12345678; #1;
    beat_a("ms_b1", 8'hBB, 1'b0);
    chk("ms_b1_rdy", {31'd0, a_in_ready}, 32'd0);
    tick();
    beat_a("ms_b2", 8'hCC, 1'b0);
    chk("ms_b2_rdy", {31'd0, a_in_ready}, 32'd0);
    tick();
    beat_a("ms_b3", 8'hDD, 1'b1);
    chk("ms_b3_rdy", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0; a_in_data = 32'h0; #1;
    beat_a("ms_n0", 8'h78, 1'b0); tick();
    beat_a("ms_n1", 8'h56, 1'b0); tick();
    beat_a("ms_n2", 8'h34, 1'b0); tick();
    beat_a("ms_n3", 8'h12, 1'b1); tick();
    idle_a("ms_end");

    // Reset mid-word discards remaining beats
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; #1;
    tick();
    a_in_valid = 1'b0; #1;
    beat_a("rs_b0", 8'hAA, 1'b0); tick();
    beat_a("rs_b1", 8'hBB, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    idle_a("rs_after");
    chk("rs_after_data", {24'd0, a_out_data}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_quiet_valid", {31'd0, a_out_valid}, 32'd0);
    end

    // 24-bit word, 3 beats
    b_in_valid = 1'b1; b_in_data = 24'hCCBBAA; #1;
    chk("b_accept_rdy", {31'd0, b_in_ready}, 32'd1);
    tick();
    b_in_valid = 1'b0; b_in_data = 24'h0; #1;
    chk("b_b0_valid", {31'd0, b_out_valid}, 32'd1);
    chk("b_b0_data", {24'd0, b_out_data}, 32'h000000AA);
    chk("b_b0_last", {31'd0, b_out_last}, 32'd0);
    tick();
    chk("b_b1_data", {24'd0, b_out_data}, 32'h000000BB);
    chk("b_b1_last", {31'd0, b_out_last}, 32'd0);
    tick();
    chk("b_b2_data", {24'd0, b_out_data}, 32'h000000CC);
    chk("b_b2_last", {31'd0, b_out_last}, 32'd1);
    tick();
    chk("b_end_valid", {31'd0, b_out_valid}, 32'd0);
    chk("b_end_busy",  {31'd0, b_busy},      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
